// File: rtl/ibex_defines.sv
// rtl/ibex_defines.sv - shared types and constants for the capability LSU sequencer
package ibex_defines;

    parameter int unsigned CAP_BUS_BEAT_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RVALID,
        DONE
    } cap_lsu_seq_state_e;

endpackage

// File: rtl/ibex_cheri_cap_lsu_seq.sv
// rtl/ibex_cheri_cap_lsu_seq.sv - splits a capability load/store into 32-bit bus beats (optional CHERI_CAP_TAG_EN)
module ibex_cheri_cap_lsu_seq
    import ibex_defines::*;
#(
    parameter int unsigned CapWidth = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [31:0]         addr_i,
    input  logic [CapWidth-1:0] wdata_i,
    output logic                ack_o,
    output logic                done_o,
    output logic [CapWidth-1:0] rdata_o,
    output logic                err_o,
    output logic                misaligned_o,
    output logic                busy_o,
`ifdef CHERI_CAP_TAG_EN
    output logic                data_tag_o,
    input  logic                data_tag_i,
    input  logic                wtag_i,
    output logic                rtag_o,
`endif
    output logic                data_req_o,
    input  logic                data_gnt_i,
    input  logic                data_rvalid_i,
    input  logic                data_err_i,
    output logic                data_we_o,
    output logic [3:0]          data_be_o,
    output logic [31:0]         data_addr_o,
    output logic [31:0]         data_wdata_o,
    input  logic [31:0]         data_rdata_i
);

    localparam int unsigned NumBeats = CapWidth / 32;
    localparam int unsigned BeatW    = $clog2(NumBeats);
    localparam int unsigned OffW     = $clog2(CapWidth / 8);

    cap_lsu_seq_state_e    state_q, state_d;
    logic [BeatW-1:0]      beat_q;
    logic                  we_q;
    logic [31:0]           addr_q;
    logic [CapWidth-1:0]   wdata_q;
    logic [CapWidth-1:0]   rdata_q;
    logic                  err_q;
    logic                  mis_q;

    logic                  accept;
    logic                  misaligned_req;
    logic                  issue;
    logic                  beat_done;
    logic                  last_beat;
    logic                  finish_access;
    logic [BeatW+4:0]      slice_lsb;
    logic [31:0]           beat_off;

    assign accept         = (state_q == IDLE) && req_i;
    assign misaligned_req = addr_i[OffW-1:0] != '0;
    assign issue          = (state_q == ISSUE);
    assign beat_done      = (state_q == WAIT_RVALID) && data_rvalid_i;
    assign last_beat      = beat_q == BeatW'(NumBeats - 1);
    // An error on any beat abandons the remaining beats.
    assign finish_access  = err_q || data_err_i || last_beat;
    assign slice_lsb      = {beat_q, 5'b00000};
    assign beat_off       = 32'(beat_q) * CAP_BUS_BEAT_BYTES;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:        if (req_i) state_d = misaligned_req ? DONE : ISSUE;
            ISSUE:       if (data_gnt_i) state_d = WAIT_RVALID;
            WAIT_RVALID: if (data_rvalid_i) state_d = finish_access ? DONE : ISSUE;
            DONE:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // Request capture, beat counting, load assembly and sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else if (accept) begin
            beat_q  <= '0;
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            err_q   <= misaligned_req;
            mis_q   <= misaligned_req;
            // Clearing here leaves unfetched slices zero if the load aborts.
            if (!we_i) begin
                rdata_q <= '0;
            end
        end else if (beat_done) begin
            if (!we_q) begin
                rdata_q[slice_lsb +: 32] <= data_rdata_i;
            end
            err_q <= err_q | data_err_i;
            if (!finish_access) begin
                beat_q <= beat_q + BeatW'(1);
            end
        end
    end

`ifdef CHERI_CAP_TAG_EN
    logic rtag_q;

    // Tag accumulates as the AND of all beat tags and drops on any error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rtag_q <= 1'b0;
        end else if (accept && !we_i) begin
            rtag_q <= !misaligned_req;
        end else if (beat_done && !we_q) begin
            rtag_q <= rtag_q & data_tag_i & ~data_err_i;
        end
    end

    assign rtag_o     = rtag_q;
    assign data_tag_o = issue & we_q & wtag_i;
`endif

    assign ack_o        = accept;
    assign done_o       = (state_q == DONE);
    assign err_o        = done_o & err_q;
    assign misaligned_o = done_o & mis_q;
    assign busy_o       = (state_q != IDLE);
    assign rdata_o      = rdata_q;

    // Bus outputs depend only on registered state, so they hold until granted.
    assign data_req_o   = issue;
    assign data_we_o    = issue & we_q;
    assign data_be_o    = issue ? 4'b1111 : 4'b0000;
    assign data_addr_o  = issue ? addr_q + beat_off : 32'h0;
    assign data_wdata_o = issue ? wdata_q[slice_lsb +: 32] : 32'h0;

endmodule

// File: tb/tb_ibex_cheri_cap_lsu_seq.sv
// tb/tb_ibex_cheri_cap_lsu_seq.sv - scoreboard bench for the capability LSU sequencer
module tb_ibex_cheri_cap_lsu_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i, we_i;
    logic [31:0] addr_i;
    logic [63:0] wdata_i;
    logic        ack_o, done_o, err_o, misaligned_o, busy_o;
    logic [63:0] rdata_o;
    logic        data_req_o, data_gnt_i, data_rvalid_i, data_err_i, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
`ifdef CHERI_CAP_TAG_EN
    logic        data_tag_o, data_tag_i, wtag_i, rtag_o;
    logic        bus_tag[$];
`endif

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        tag;
    } beat_t;

    typedef struct {
        logic        err;
        logic        mis;
        logic [63:0] rdata;
        int          lat;
        logic        rtag;
    } resp_t;

    beat_t       exp_beats[$];
    resp_t       exp_resps[$];
    logic [31:0] bus_rdata[$];
    logic        bus_err[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ack_cyc = 0;
    int gnt_delay = 0;
    int rv_delay = 0;

    beat_t       b;
    resp_t       r;
    logic        prev_done = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;

    ibex_cheri_cap_lsu_seq #(.CapWidth(64)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .ack_o        (ack_o),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .misaligned_o (misaligned_o),
        .busy_o       (busy_o),
`ifdef CHERI_CAP_TAG_EN
        .data_tag_o   (data_tag_o),
        .data_tag_i   (data_tag_i),
        .wtag_i       (wtag_i),
        .rtag_o       (rtag_o),
`endif
        .data_req_o   (data_req_o),
        .data_gnt_i   (data_gnt_i),
        .data_rvalid_i(data_rvalid_i),
        .data_err_i   (data_err_i),
        .data_we_o    (data_we_o),
        .data_be_o    (data_be_o),
        .data_addr_o  (data_addr_o),
        .data_wdata_o (data_wdata_o),
        .data_rdata_i (data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // Bus slave: grant after gnt_delay cycles, respond rv_delay cycles after the grant.
    initial begin
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;
`ifdef CHERI_CAP_TAG_EN
        data_tag_i = 1'b0;
`endif
        forever begin
            @(posedge clk_i); #1;
            data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;
`ifdef CHERI_CAP_TAG_EN
            data_tag_i = 1'b0;
`endif
            if (data_req_o) begin
                repeat (gnt_delay) begin @(posedge clk_i); #1; end
                data_gnt_i = 1'b1;
                @(posedge clk_i); #1;
                data_gnt_i = 1'b0;
                repeat (rv_delay) begin @(posedge clk_i); #1; end
                data_rvalid_i = 1'b1;
                data_rdata_i  = (bus_rdata.size() > 0) ? bus_rdata.pop_front() : 32'h0;
                data_err_i    = (bus_err.size() > 0) ? bus_err.pop_front() : 1'b0;
`ifdef CHERI_CAP_TAG_EN
                data_tag_i    = (bus_tag.size() > 0) ? bus_tag.pop_front() : 1'b0;
`endif
            end
        end
    end

    // Beat monitor: every granted beat must match the next expected beat; stalled beats must hold.
    always @(negedge clk_i) begin
        if (data_req_o && data_gnt_i) begin
            if (exp_beats.size() == 0) begin
                fail_now("unexpected_beat");
            end else begin
                b = exp_beats.pop_front();
                check("beat_addr", data_addr_o, b.addr);
                check("beat_we", data_we_o, b.we);
                check("beat_be", data_be_o, 4'b1111);
                if (b.we) check("beat_wdata", data_wdata_o, b.wdata);
`ifdef CHERI_CAP_TAG_EN
                check("beat_tag", data_tag_o, b.tag);
`endif
            end
        end
        if (prev_stall && data_req_o) begin
            check("stall_addr", data_addr_o, p_addr);
            check("stall_wdata", data_wdata_o, p_wdata);
            check("stall_we", data_we_o, p_we);
        end
        prev_stall = data_req_o && !data_gnt_i;
        p_addr  = data_addr_o;
        p_wdata = data_wdata_o;
        p_we    = data_we_o;
    end

    // Response monitor: each done pulse pops and checks the next expected response.
    always @(negedge clk_i) begin
        if (done_o) begin
            if (exp_resps.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                r = exp_resps.pop_front();
                check("err", err_o, r.err);
                check("misaligned", misaligned_o, r.mis);
                check("rdata", rdata_o, r.rdata);
                if (r.lat > 0) check("latency", cyc - ack_cyc, r.lat);
`ifdef CHERI_CAP_TAG_EN
                check("rtag", rtag_o, r.rtag);
`endif
            end
        end
        if (done_o && prev_done) fail_now("done_width");
        prev_done = done_o;
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [63:0] wd);
        @(posedge clk_i); #1;
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
        @(negedge clk_i);
        check("ack", ack_o, 1'b1);
        ack_cyc = cyc;
        @(posedge clk_i); #1;
        req_i = 1'b0;
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while ((exp_resps.size() != 0 || exp_beats.size() != 0) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d pending responses, expected 0", exp_resps.size());
        end
        @(negedge clk_i);
    endtask

    task automatic push_load(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                             input logic t0, input logic t1);
        bus_rdata.push_back(d0); bus_rdata.push_back(d1);
        bus_err.push_back(1'b0); bus_err.push_back(1'b0);
`ifdef CHERI_CAP_TAG_EN
        bus_tag.push_back(t0); bus_tag.push_back(t1);
`endif
        exp_beats.push_back('{addr, 1'b0, 32'h0, 1'b0});
        exp_beats.push_back('{addr + 32'h4, 1'b0, 32'h0, 1'b0});
    endtask

    initial begin
        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
`ifdef CHERI_CAP_TAG_EN
        wtag_i = 1'b1;
`endif
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_busy", busy_o, 1'b0);
        check("rst_req", data_req_o, 1'b0);
        check("rst_be", data_be_o, 4'b0000);
        check("rst_rdata", rdata_o, 64'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Two-beat load with one-cycle late grant and rvalid.
        gnt_delay = 1; rv_delay = 1;
        push_load(32'h1000, 32'hAAAA0001, 32'hBBBB0002, 1'b1, 1'b1);
        exp_resps.push_back('{1'b0, 1'b0, 64'hBBBB0002AAAA0001, 9, 1'b1});
        issue(1'b0, 32'h1000, 64'h0);
        @(negedge clk_i);
        check("busy_in_flight", busy_o, 1'b1);
        wait_resp();

        // Store with a stalled grant; rdata_o and rtag_o keep the previous load result.
        gnt_delay = 3; rv_delay = 0;
        exp_beats.push_back('{32'h2008, 1'b1, 32'h55667788, 1'b1});
        exp_beats.push_back('{32'h200C, 1'b1, 32'h11223344, 1'b1});
        exp_resps.push_back('{1'b0, 1'b0, 64'hBBBB0002AAAA0001, 0, 1'b1});
        issue(1'b1, 32'h2008, 64'h1122334455667788);
        wait_resp();

        // Misaligned load finishes the next cycle with no bus traffic.
        gnt_delay = 0; rv_delay = 0;
        exp_resps.push_back('{1'b1, 1'b1, 64'h0, 1, 1'b0});
        issue(1'b0, 32'h1004, 64'h0);
        wait_resp();

        // Bus error on the first beat aborts the second.
        bus_rdata.push_back(32'h0); bus_err.push_back(1'b1);
`ifdef CHERI_CAP_TAG_EN
        bus_tag.push_back(1'b1);
`endif
        exp_beats.push_back('{32'h3000, 1'b0, 32'h0, 1'b0});
        exp_resps.push_back('{1'b1, 1'b0, 64'h0, 3, 1'b0});
        issue(1'b0, 32'h3000, 64'h0);
        wait_resp();

        // Reset while waiting for rvalid; the late rvalid must be ignored.
        rv_delay = 4;
        bus_rdata.push_back(32'hFFFFFFFF); bus_err.push_back(1'b0);
`ifdef CHERI_CAP_TAG_EN
        bus_tag.push_back(1'b1);
`endif
        exp_beats.push_back('{32'h4000, 1'b0, 32'h0, 1'b0});
        issue(1'b0, 32'h4000, 64'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_done", done_o, 1'b0);
        check("mid_rst_err", err_o, 1'b0);
        check("mid_rst_req", data_req_o, 1'b0);
        check("mid_rst_we", data_we_o, 1'b0);
        check("mid_rst_addr", data_addr_o, 32'h0);
        check("mid_rst_wdata", data_wdata_o, 32'h0);
        check("mid_rst_be", data_be_o, 4'b0000);
        check("mid_rst_rdata", rdata_o, 64'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (8) @(posedge clk_i);
        @(negedge clk_i);
        check("post_rst_busy", busy_o, 1'b0);
        check("post_rst_rdata", rdata_o, 64'h0);

        // Back-to-back zero-wait load shows the minimum latency.
        rv_delay = 0;
        push_load(32'h5000, 32'h00000003, 32'h00000004, 1'b1, 1'b1);
        exp_resps.push_back('{1'b0, 1'b0, 64'h0000000400000003, 5, 1'b1});
        issue(1'b0, 32'h5000, 64'h0);
        wait_resp();

`ifdef CHERI_CAP_TAG_EN
        push_load(32'h6000, 32'h00000005, 32'h00000006, 1'b1, 1'b0);
        exp_resps.push_back('{1'b0, 1'b0, 64'h0000000600000005, 5, 1'b0});
        issue(1'b0, 32'h6000, 64'h0);
        wait_resp();
        push_load(32'h6008, 32'h00000007, 32'h00000008, 1'b1, 1'b1);
        exp_resps.push_back('{1'b0, 1'b0, 64'h0000000800000007, 5, 1'b1});
        issue(1'b0, 32'h6008, 64'h0);
        wait_resp();
`endif

        repeat (3) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ibex_cheri_cap_lsu_seq.md
IBEX_CHERI_CAP_LSU_SEQ -- requirements
Module: ibex_cheri_cap_lsu_seq

Interface
REQ-001 SHALL have parameter CapWidth, default 64, capability data width in bits (multiple of 32, at least 64).
REQ-002 SHALL have parameter NumBeats, default CapWidth/32, bus beats per capability access (derived, not overridable).
REQ-003 SHALL have port clk_i  input  1  clock.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_i  input  1  LQ/SQ request from ID/EX, held until ack_o.
REQ-006 SHALL have port we_i  input  1  1 = store capability, 0 = load capability.
REQ-007 SHALL have port addr_i  input  32  capability base address.
REQ-008 SHALL have port wdata_i  input  CapWidth  store data.
REQ-009 SHALL have port ack_o  output  1  one-cycle pulse: request accepted.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse: access finished, rdata_o/err_o valid.
REQ-011 SHALL have port rdata_o  output  CapWidth  assembled load data.
REQ-012 SHALL have port err_o  output  1  bus error or misalignment, valid with done_o.
REQ-013 SHALL have port misaligned_o  output  1  error was misalignment, valid with done_o.
REQ-014 SHALL have port busy_o  output  1  FSM not IDLE.
REQ-015 SHALL have ports data_req_o out 1, data_gnt_i in 1, data_rvalid_i in 1, data_err_i in 1, data_we_o out 1, data_be_o out 4, data_addr_o out 32, data_wdata_o out 32, data_rdata_i in 32: 32-bit data bus.
REQ-016 SHALL have, only with CHERI_CAP_TAG_EN, ports data_tag_o out 1, data_tag_i in 1, wtag_i in 1, rtag_o out 1.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT_RVALID, DONE.
REQ-018 IDLE + req_i: ack_o=1 same cycle; capture we_i, addr_i, wdata_i; beat counter=0; go ISSUE, or DONE with err_o=misaligned_o=1 if addr_i[log2(CapWidth/8)-1:0] != 0 (no bus beat issued).
REQ-019 ISSUE: data_req_o=1, data_addr_o=base+4*beat, data_be_o=4'b1111, data_wdata_o=captured data[32*beat+:32], data_we_o=captured we; on data_gnt_i go WAIT_RVALID.
REQ-020 data_req_o and all data_* outputs SHALL stay stable until data_gnt_i.
REQ-021 WAIT_RVALID: on data_rvalid_i store data_rdata_i into rdata slice [32*beat+:32] (loads only); OR data_err_i into sticky error.
REQ-022 On rvalid: if error set or beat==NumBeats-1 go DONE, else beat+1 and go ISSUE (remaining beats aborted on error).
REQ-023 DONE: done_o=1 for exactly one cycle, then IDLE; new request accepted earliest the following cycle.
REQ-024 Only one bus beat outstanding; minimum load latency ack_o to done_o = 2*NumBeats+1 cycles with gnt and rvalid each one cycle after assertion.
REQ-025 rdata_o SHALL hold its value from DONE until next accepted load; zero-filled slices on aborted loads.
REQ-026 Stores SHALL not modify rdata_o.
REQ-027 data_rvalid_i outside WAIT_RVALID SHALL be ignored.

Reset
REQ-028 On rst_ni low, asynchronously: state IDLE, beat 0, rdata_o 0, error 0; ack_o, done_o, err_o, misaligned_o, busy_o, data_req_o, data_we_o all 0; data_addr_o, data_wdata_o 0; data_be_o 4'b0000.
REQ-029 Reset mid-access SHALL abandon the access without done_o.

Configuration
REQ-030 With CHERI_CAP_TAG_EN defined: data_tag_o=wtag_i on every store beat; rtag_o=AND of data_tag_i over all load beats, forced 0 on err_o, registered with rdata_o, reset 0.
REQ-031 Without CHERI_CAP_TAG_EN: tag ports absent, no tag storage.

Structure
REQ-032 Package ibex_defines SHALL gain typedef cap_lsu_seq_state_e (IDLE, ISSUE, WAIT_RVALID, DONE) and parameter CAP_BUS_BEAT_BYTES = 4.
REQ-033 SHALL be a single module, no sub-modules; beat counter width $clog2(NumBeats).

Verification
REQ-034 Load addr 0x1000, gnt and rvalid each 1 cycle late, rdata 0xAAAA0001 then 0xBBBB0002 -> addresses 0x1000, 0x1004; rdata_o=0xBBBB0002AAAA0001, err_o=0, done_o one pulse.
REQ-035 Store addr 0x2008, wdata 0x1122334455667788, gnt delayed 3 cycles -> beats 0x55667788 @0x2008, 0x11223344 @0x200C, outputs stable while stalled.
REQ-036 Load addr 0x1004 -> ack_o, done_o next cycle with err_o=misaligned_o=1, data_req_o never high.
REQ-037 Load addr 0x3000, data_err_i on beat 0 -> no second beat, done_o with err_o=1, misaligned_o=0.
REQ-038 rst_ni low while in WAIT_RVALID -> all outputs reset values, no done_o; next load completes normally.
REQ-039 CHERI_CAP_TAG_EN, load with data_tag_i 1 then 0 -> rtag_o=0; with 1 and 1 -> rtag_o=1.
